// File: rtl/btb_pkg.sv
// Shared constants for the branch target buffer: geometry defaults and
// 2-bit direction counter encodings.
package btb_pkg;

   localparam int ENTRIES_DEF  = 16;
   localparam int IDX_BITS_DEF = 4;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } ctr_e;

   // A freshly allocated entry starts weakly taken: it was just seen taken.
   localparam logic [1:0] CTR_ALLOC = WEAK_T;

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic of a 2-bit saturating up/down direction counter.
module sat_counter2
   import btb_pkg::*;
(
   input  logic [1:0] ctr_i,
   input  logic       inc_i,
   output logic [1:0] ctr_o
);

   always_comb begin
      ctr_o = ctr_i;
      if (inc_i) begin
         if (ctr_i != STRONG_T) ctr_o = ctr_i + 2'd1;
      end else begin
         if (ctr_i != STRONG_NT) ctr_o = ctr_i - 2'd1;
      end
   end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational IF lookup, combinational ID mispredict
// detection, and registered training from resolved beq/bne outcomes.
module branch_target_buffer
   import btb_pkg::*;
#(
   parameter int ENTRIES  = ENTRIES_DEF,
   parameter int IDX_BITS = $clog2(ENTRIES),
   parameter int TAG_BITS = 30 - IDX_BITS
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] FetchPC,
   output logic        PredictTaken,
   output logic [31:0] PredictedTarget,
   input  logic        UpdateValid,
   input  logic [31:0] UpdatePC,
   input  logic        UpdateTaken,
   input  logic [31:0] UpdateTarget,
   input  logic        UpdatePredTaken,
   input  logic [31:0] UpdatePredTarget,
   output logic        Mispredict,
   output logic [31:0] CorrectPC,
   output logic [31:0] HitCount,
   output logic [31:0] MispredictCount
);

   // Flop arrays so the IF read is asynchronous; only valid bits are reset.
   logic [ENTRIES-1:0]  valid_q, valid_d;
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   logic [1:0]          ctr_q    [ENTRIES];
   logic [31:0]         hit_cnt_q, hit_cnt_d;
   logic [31:0]         misp_cnt_q, misp_cnt_d;

   logic [IDX_BITS-1:0] fetch_idx, upd_idx;
   logic [TAG_BITS-1:0] fetch_tag, upd_tag;
   logic                fetch_hit, upd_hit;
   logic [31:0]         fetch_seq, upd_seq;
   logic [31:0]         actual_pc, predicted_pc;
   logic [1:0]          ctr_trained, ctr_wr;
   logic                wr_en;
   logic                unused_pc_bits;

   // Instructions are word aligned, so PC[1:0] carry no information.
   assign unused_pc_bits = ^{FetchPC[1:0], UpdatePC[1:0]};

   // IF lookup
   assign fetch_idx       = FetchPC[IDX_BITS+1:2];
   assign fetch_tag       = FetchPC[31:IDX_BITS+2];
   assign fetch_hit       = valid_q[fetch_idx] & (tag_q[fetch_idx] == fetch_tag);
   assign fetch_seq       = FetchPC + 32'd4;
   assign PredictTaken    = fetch_hit & ctr_q[fetch_idx][1];
   assign PredictedTarget = PredictTaken ? target_q[fetch_idx] : fetch_seq;

   // ID resolution
   assign upd_seq      = UpdatePC + 32'd4;
   assign actual_pc    = UpdateTaken ? UpdateTarget : upd_seq;
   assign predicted_pc = UpdatePredTaken ? UpdatePredTarget : upd_seq;
   assign Mispredict   = UpdateValid & (actual_pc != predicted_pc);
   assign CorrectPC    = UpdateValid ? actual_pc : upd_seq;

   // Training: read the indexed entry again on the update path
   assign upd_idx = UpdatePC[IDX_BITS+1:2];
   assign upd_tag = UpdatePC[31:IDX_BITS+2];
   assign upd_hit = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);

   sat_counter2 u_ctr (
      .ctr_i (ctr_q[upd_idx]),
      .inc_i (UpdateTaken),
      .ctr_o (ctr_trained)
   );

   // A not-taken miss never allocates, so the slot's current owner survives.
   assign wr_en  = UpdateValid & (upd_hit | UpdateTaken);
   assign ctr_wr = upd_hit ? ctr_trained : CTR_ALLOC;

   always_comb begin
      valid_d    = valid_q;
      hit_cnt_d  = hit_cnt_q;
      misp_cnt_d = misp_cnt_q;
      if (wr_en) valid_d[upd_idx] = 1'b1;
      if (fetch_hit) hit_cnt_d = hit_cnt_q + 32'd1;
      if (Mispredict) misp_cnt_d = misp_cnt_q + 32'd1;
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         valid_q    <= '0;
         hit_cnt_q  <= '0;
         misp_cnt_q <= '0;
      end else begin
         valid_q    <= valid_d;
         hit_cnt_q  <= hit_cnt_d;
         misp_cnt_q <= misp_cnt_d;
      end
   end

   // Payload arrays; a write coinciding with reset is dropped.
   always_ff @(posedge Clk) begin
      if (Reset && wr_en) begin
         ctr_q[upd_idx] <= ctr_wr;
         if (UpdateTaken) target_q[upd_idx] <= UpdateTarget;
         if (!upd_hit) tag_q[upd_idx] <= upd_tag;
      end
   end

   assign HitCount        = hit_cnt_q;
   assign MispredictCount = misp_cnt_q;

endmodule
